// File: rtl/cv32e40p_x_offload_queue.sv
// cv32e40p_x_offload_queue
// ------------------------
// Decouples the core's offload interface from a coprocessor. Requests pass
// through a DEPTH-entry FIFO. Results come back through a one-entry response
// register. The block also counts writebacks that have been issued to the
// coprocessor but not yet consumed by the core. Requests that need a
// writeback are held back while DEPTH results are already owed.
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// valid and ready are both high at the rising edge of clk_i. A producer keeps
// valid and its payload stable until the transfer happens. ready may depend
// on valid. valid never depends on ready.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   x_valid_i/x_ready_o, x_rs_i, x_rs_valid_i, x_writeback_i
//                       core -> queue request
//   cop_valid_o/cop_ready_i, cop_rs_o, cop_rs_valid_o, cop_writeback_o
//                       queue -> coprocessor request (head of FIFO)
//   cop_rvalid_i/cop_rready_o, cop_rd_i, cop_data_i, cop_error_i
//                       coprocessor -> queue response
//   x_rvalid_o/x_rready_i, x_rd_o, x_data_o, x_error_o
//                       queue -> core response
//   flush_i             drop every queued request on the next edge
//   outstanding_o       writebacks issued but not yet taken by the core
//   empty_o             request FIFO is empty
//   spurious_o          one-cycle pulse when an unexpected response is dropped
//
// Optional feature: define CV32E40P_X_BYPASS_EN to let a request pass
// straight through to the coprocessor when the FIFO is empty.
module cv32e40p_x_offload_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // core request
  input  logic                         x_valid_i,
  output logic                         x_ready_o,
  input  logic [2:0][31:0]             x_rs_i,
  input  logic [2:0]                   x_rs_valid_i,
  input  logic                         x_writeback_i,
  // coprocessor request
  output logic                         cop_valid_o,
  input  logic                         cop_ready_i,
  output logic [2:0][31:0]             cop_rs_o,
  output logic [2:0]                   cop_rs_valid_o,
  output logic                         cop_writeback_o,
  // coprocessor response
  input  logic                         cop_rvalid_i,
  output logic                         cop_rready_o,
  input  logic [4:0]                   cop_rd_i,
  input  logic [31:0]                  cop_data_i,
  input  logic                         cop_error_i,
  // core response
  output logic                         x_rvalid_o,
  input  logic                         x_rready_i,
  output logic [4:0]                   x_rd_o,
  output logic [31:0]                  x_data_o,
  output logic                         x_error_o,
  // control / status
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         empty_o,
  output logic                         spurious_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // request storage
  logic [2:0][31:0] rs_mem  [DEPTH];
  logic [2:0]       rsv_mem [DEPTH];
  logic [DEPTH-1:0] wb_mem;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic fifo_empty, fifo_full;
  logic wb_stall;
  logic issue, issue_wb;
  logic push, pop;
  logic rsp_hs, rsp_take, rsp_spurious;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign x_ready_o  = !fifo_full;
  assign empty_o    = fifo_empty;

  // A writeback request may not issue while every result slot is owed.
  assign wb_stall = (outstanding_o == CW'(DEPTH));

  always_comb begin
    cop_valid_o     = 1'b0;
    cop_rs_o        = '0;
    cop_rs_valid_o  = '0;
    cop_writeback_o = 1'b0;
    if (!fifo_empty) begin
      cop_valid_o     = !(wb_mem[rptr] && wb_stall);
      cop_rs_o        = rs_mem[rptr];
      cop_rs_valid_o  = rsv_mem[rptr];
      cop_writeback_o = wb_mem[rptr];
    end
`ifdef CV32E40P_X_BYPASS_EN
    else if (x_valid_i) begin
      cop_valid_o     = !(x_writeback_i && wb_stall);
      cop_rs_o        = x_rs_i;
      cop_rs_valid_o  = x_rs_valid_i;
      cop_writeback_o = x_writeback_i;
    end
`endif
  end

  assign issue    = cop_valid_o && cop_ready_i;
  assign issue_wb = issue && cop_writeback_o;
  assign pop      = issue && !fifo_empty;
  // An issue while the FIFO is empty can only be the bypassed request, which
  // must not also be stored. A flush wins over any push.
  assign push     = x_valid_i && x_ready_o && !flush_i && !(issue && fifo_empty);

  always_ff @(posedge clk_i) begin
    if (push) begin
      rs_mem[wptr]  <= x_rs_i;
      rsv_mem[wptr] <= x_rs_valid_i;
      wb_mem[wptr]  <= x_writeback_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // response path
  assign cop_rready_o = !x_rvalid_o || x_rready_i;
  assign rsp_hs       = cop_rvalid_i && cop_rready_o;
  assign rsp_take     = x_rvalid_o && x_rready_i;
  // outstanding_o still counts the result held in the response register.
  // The coprocessor owes nothing more once the count equals that held
  // result. This also covers outstanding_o == 0, which implies an empty
  // register.
  assign rsp_spurious = rsp_hs && (outstanding_o == CW'(x_rvalid_o));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_o <= '0;
    end else begin
      outstanding_o <= outstanding_o + CW'(issue_wb) - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_rvalid_o <= 1'b0;
      x_rd_o     <= '0;
      x_data_o   <= '0;
      x_error_o  <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      spurious_o <= rsp_spurious;
      if (rsp_hs && !rsp_spurious) begin
        x_rvalid_o <= 1'b1;
        x_rd_o     <= cop_rd_i;
        x_data_o   <= cop_data_i;
        x_error_o  <= cop_error_i;
      end else if (rsp_take) begin
        x_rvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cv32e40p_x_offload_queue.md
CV32E40P_X_OFFLOAD_QUEUE -- requirements
Module: cv32e40p_x_offload_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries and max outstanding writebacks (power of two, 2..16).
REQ-002 SHALL have ports: clk_i  in  1  single clock, all logic rising-edge; rst_i  in  1  asynchronous active-high reset.
REQ-003 SHALL have core-side request ports: x_valid_i in 1; x_ready_o out 1; x_rs_i in 3x32 operands; x_rs_valid_i in 3; x_writeback_i in 1 (instruction returns result).
REQ-004 SHALL have coprocessor-side request ports: cop_valid_o out 1; cop_ready_i in 1; cop_rs_o out 3x32; cop_rs_valid_o out 3; cop_writeback_o out 1.
REQ-005 SHALL have coprocessor response ports: cop_rvalid_i in 1; cop_rready_o out 1; cop_rd_i in 5; cop_data_i in 32; cop_error_i in 1.
REQ-006 SHALL have core response ports: x_rvalid_o out 1; x_rready_i in 1; x_rd_o out 5; x_data_o out 32; x_error_o out 1.
REQ-007 SHALL have control/status: flush_i in 1; outstanding_o out clog2(DEPTH+1); empty_o out 1; spurious_o out 1.

Function
REQ-008 Request path SHALL be a DEPTH-entry FIFO of {rs, rs_valid, writeback}; push on x_valid_i & x_ready_o, pop on cop_valid_o & cop_ready_i.
REQ-009 x_ready_o SHALL equal !full, independent of same-cycle pop (no push at full even if popping).
REQ-010 Push and pop in same cycle with FIFO neither full nor empty SHALL leave count unchanged and preserve order.
REQ-011 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, full = (count==DEPTH), empty_o = (count==0).
REQ-012 cop_valid_o SHALL be !empty, except held low while head writeback=1 and outstanding_o==DEPTH; cop_* data SHALL show head entry and stay stable while cop_valid_o & !cop_ready_i.
REQ-013 Without bypass, request accepted in cycle N SHALL appear on cop_valid_o no earlier than N+1.
REQ-014 outstanding_o SHALL increment on a popped writeback=1 request, decrement on x_rvalid_o & x_rready_i, unchanged when both occur.
REQ-015 Response path SHALL be a one-entry register: cop_rready_o = !x_rvalid_o | x_rready_i; on cop handshake load rd/data/error, x_rvalid_o set next cycle.
REQ-016 Back-to-back responses SHALL sustain one per cycle when x_rready_i stays high.
REQ-017 Coprocessor response accepted while outstanding_o==0 and no pending decrement SHALL be dropped, not forwarded, and pulse spurious_o high for exactly one cycle.
REQ-018 flush_i SHALL empty the FIFO next cycle, overriding a same-cycle push; a same-cycle pop handshake SHALL still count toward outstanding_o; response register and outstanding_o SHALL not be cleared by flush.
REQ-019 x_error_o SHALL pass cop_error_i with its response; error SHALL not alter counters.

Reset
REQ-020 rst_i asserted SHALL immediately clear pointers, count, outstanding_o, response register and spurious_o.
REQ-021 During/after reset until first push: x_ready_o=1 (after deassert), cop_valid_o=0, x_rvalid_o=0, empty_o=1, cop_rready_o=1, all data outputs 0.
REQ-022 Reset mid-transfer SHALL discard all queued requests and the pending response without output glitches beyond the asynchronous clear.

Configuration
REQ-023 Macro CV32E40P_X_BYPASS_EN defined: when FIFO empty and x_valid_i high, request SHALL drive cop_* combinationally same cycle; if cop_ready_i also high it SHALL not be written to FIFO (zero latency).
REQ-024 Macro CV32E40P_X_BYPASS_EN undefined: no combinational path from x_* request inputs to cop_* outputs; REQ-013 latency applies.

Verification
REQ-025 DEPTH=4, cop_ready_i=0, push 5 requests rs0=1..5 -> x_ready_o=0 after 4th, count 4; release cop_ready_i -> cop_rs_o[0] sequence 1,2,3,4, then 5 after re-push.
REQ-026 Issue 4 writeback=1 requests, withhold responses -> outstanding_o=4, 5th writeback request held with cop_valid_o=0; one response handshake -> outstanding_o=3, 5th issues next cycle.
REQ-027 x_rready_i=0, cop sends rd=5 data=0xDEADBEEF -> x_rvalid_o=1 holding values, cop_rready_o=0; second response stalls until x_rready_i=1.
REQ-028 outstanding_o=0, cop_rvalid_i=1 rd=3 -> spurious_o one-cycle pulse, x_rvalid_o stays 0.
REQ-029 FIFO holding 3 entries, flush_i with simultaneous push -> empty_o=1 next cycle, pushed entry lost, outstanding_o unchanged.
REQ-030 With CV32E40P_X_BYPASS_EN, empty FIFO, x_valid_i=cop_ready_i=1 rs0=0x10 -> cop_valid_o=1 and cop_rs_o[0]=0x10 same cycle, empty_o stays 1.
